neander_io_responder: RTL and testbench

NEANDER_IO_RESPONDER -- requirements
Module: neander_io_responder

---
 rtl/neander_io_responder.sv | 147 ++++++++++++++
 tb/tb_neander_io_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/neander_io_responder.sv
// Neander CPU I/O port responder: TX byte queue toward the device, single-byte RX holding register, status byte.
// Define NEANDER_IO_TXFIFO_EN for a TX_DEPTH-entry TX FIFO; otherwise TX is a single holding register.
module neander_io_responder #(
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_write,
  input  logic [7:0] io_out,
  input  logic       io_read,
  input  logic       io_stat_read,
  output logic [7:0] io_in,
  output logic [7:0] io_status,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  if (TX_DEPTH < 2 || TX_DEPTH > 16 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TX_DEPTH must be a power of two in 2..16");
  end

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_pop  = tx_valid & tx_ready;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_push = io_write & (~w_full | w_pop);
  assign w_drop = io_write & w_full & ~w_pop;

`ifdef NEANDER_IO_TXFIFO_EN
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [TX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign w_full   = (r_count == CNT_W'(TX_DEPTH));
  assign w_empty  = (r_count == '0);
  assign tx_valid = ~w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_out;
    end
  end

  // Pointers wrap naturally because TX_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_tx_hold;
  logic       r_tx_valid;

  assign w_full   = r_tx_valid;
  assign w_empty  = ~r_tx_valid;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_valid ? r_tx_hold : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_hold  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_push) begin
      r_tx_hold  <= io_out;
      r_tx_valid <= 1'b1;
    end else if (w_pop) begin
      r_tx_valid <= 1'b0;
    end
  end
`endif

  logic [7:0] r_rx_data;
  logic       r_rx_full;
  logic       r_tx_drop;
  logic       r_rx_under;
  logic       w_rx_take;
  logic       w_rx_clear;
  logic       w_rx_under_set;

  assign rx_ready       = ~r_rx_full;
  assign w_rx_take      = rx_valid & ~r_rx_full;
  assign w_rx_clear     = io_read & r_rx_full;
  assign w_rx_under_set = io_read & ~r_rx_full;

  // Take and clear are mutually exclusive, so a freed slot refills one cycle later at the earliest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data <= 8'h00;
      r_rx_full <= 1'b0;
    end else if (w_rx_take) begin
      r_rx_data <= rx_data;
      r_rx_full <= 1'b1;
    end else if (w_rx_clear) begin
      r_rx_full <= 1'b0;
    end
  end

  // Sticky error flags: a set in the status-read cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_drop  <= 1'b0;
      r_rx_under <= 1'b0;
    end else begin
      if (w_drop) begin
        r_tx_drop <= 1'b1;
      end else if (io_stat_read) begin
        r_tx_drop <= 1'b0;
      end
      if (w_rx_under_set) begin
        r_rx_under <= 1'b1;
      end else if (io_stat_read) begin
        r_rx_under <= 1'b0;
      end
    end
  end

  assign io_in     = r_rx_full ? r_rx_data : 8'h00;
  assign io_status = {3'b000, r_rx_under, r_tx_drop, w_empty, w_full, r_rx_full};

endmodule

// File: tb/tb_neander_io_responder.sv
// Directed self-checking bench for neander_io_responder; expectations follow the build's effective TX depth.
module tb_neander_io_responder;

`ifdef NEANDER_IO_TXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       io_write;
  logic [7:0] io_out;
  logic       io_read;
  logic       io_stat_read;
  logic [7:0] io_in;
  logic [7:0] io_status;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neander_io_responder #(.TX_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_write     (io_write),
    .io_out       (io_out),
    .io_read      (io_read),
    .io_stat_read (io_stat_read),
    .io_in        (io_in),
    .io_status    (io_status),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] b);
    io_write = 1'b1;
    io_out   = b;
    tick();
    io_write = 1'b0;
    $display("io_write 0x%02h -> tx_valid=%0b tx_data=0x%02h status=0x%02h", b, tx_valid, tx_data, io_status);
  endtask

  task automatic do_stat_read();
    io_stat_read = 1'b1;
    tick();
    io_stat_read = 1'b0;
    $display("io_stat_read -> status=0x%02h", io_status);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; io_write = 0; io_out = 0; io_read = 0; io_stat_read = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    #3;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    checks++; if (io_in !== 8'h00) begin failures++; $display("FAIL reset_io_in got=%h exp=00", io_in); end
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL reset_status got=%h exp=04", io_status); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_tx_order();
    logic [7:0] exp_q[$];
    logic [7:0] exp_st;
    do_write(8'h11);
    checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL order_valid got=%b exp=1", tx_valid); end
    checks++; if (tx_data !== 8'h11) begin failures++; $display("FAIL order_head got=%h exp=11", tx_data); end
    do_write(8'h22);
    do_write(8'h33);
    exp_st = (DEPTH == 1) ? 8'h0A : 8'h00;
    checks++; if (io_status !== exp_st) begin failures++; $display("FAIL order_status got=%h exp=%h", io_status, exp_st); end
    exp_q = (DEPTH == 1) ? '{8'h11} : '{8'h11, 8'h22, 8'h33};
    tx_ready = 1'b1;
    foreach (exp_q[i]) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
        failures++; $display("FAIL order_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]);
      end
      tick();
      $display("tx pop expected 0x%02h", exp_q[i]);
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL order_empty got=%b/%h exp=0/00", tx_valid, tx_data); end
    exp_st = (DEPTH == 1) ? 8'h0C : 8'h04;
    checks++; if (io_status !== exp_st) begin failures++; $display("FAIL order_end_status got=%h exp=%h", io_status, exp_st); end
    do_stat_read();
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL order_clear got=%h exp=04", io_status); end
  endtask

  task automatic test_overflow();
    int n;
    for (int i = 0; i < 5; i++) do_write(8'hA0 + 8'(i));
    checks++; if (io_status !== 8'h0A) begin failures++; $display("FAIL ovf_status got=%h exp=0A", io_status); end
    do_stat_read();
    checks++; if (io_status !== 8'h02) begin failures++; $display("FAIL ovf_drop_clear got=%h exp=02", io_status); end
    n = (DEPTH < 5) ? DEPTH : 5;
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hA0 + 8'(i)) begin
        failures++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'hA0 + 8'(i));
      end
      tick();
    end
    tx_ready = 1'b0;
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL ovf_end got=%h exp=04", io_status); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q[$];
    for (int i = 0; i < DEPTH; i++) do_write(8'hC0 + 8'(i));
    checks++; if (io_status !== 8'h02) begin failures++; $display("FAIL fpp_full got=%h exp=02", io_status); end
    io_write = 1'b1; io_out = 8'h55; tx_ready = 1'b1;
    tick();
    io_write = 1'b0; tx_ready = 1'b0;
    $display("io_write 0x55 with pop -> status=0x%02h", io_status);
    for (int i = 1; i < DEPTH; i++) exp_q.push_back(8'hC0 + 8'(i));
    exp_q.push_back(8'h55);
    checks++; if (io_status !== 8'h02) begin failures++; $display("FAIL fpp_no_drop got=%h exp=02", io_status); end
    tx_ready = 1'b1;
    foreach (exp_q[i]) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
        failures++; $display("FAIL fpp_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]);
      end
      tick();
    end
    tx_ready = 1'b0;
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL fpp_end got=%h exp=04", io_status); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h7E;
    tick();
    rx_valid = 1'b0;
    $display("rx push 0x7E -> io_in=0x%02h", io_in);
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rx_ready_low got=%b exp=0", rx_ready); end
    checks++; if (io_in !== 8'h7E) begin failures++; $display("FAIL rx_io_in got=%h exp=7E", io_in); end
    checks++; if (io_status !== 8'h05) begin failures++; $display("FAIL rx_status got=%h exp=05", io_status); end
    rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    rx_valid = 1'b0;
    checks++; if (io_in !== 8'h7E) begin failures++; $display("FAIL rx_hold got=%h exp=7E", io_in); end
    io_read = 1'b1; tick(); io_read = 1'b0;
    $display("io_read -> io_in=0x%02h", io_in);
    checks++; if (rx_ready !== 1'b1 || io_in !== 8'h00) begin failures++; $display("FAIL rx_consume got=%b/%h exp=1/00", rx_ready, io_in); end
    io_read = 1'b1; tick(); io_read = 1'b0;
    checks++; if (io_status !== 8'h14) begin failures++; $display("FAIL rx_under got=%h exp=14", io_status); end
    io_read = 1'b1; io_stat_read = 1'b1; tick(); io_read = 1'b0; io_stat_read = 1'b0;
    checks++; if (io_status !== 8'h14) begin failures++; $display("FAIL rx_set_wins got=%h exp=14", io_status); end
    do_stat_read();
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL rx_clear got=%h exp=04", io_status); end
  endtask

  task automatic test_concurrent();
    logic [7:0] exp_st;
    rx_valid = 1'b1; rx_data = 8'h81;
    tick();
    // keep rx_valid high with new data across the consuming read
    rx_data = 8'h42; io_read = 1'b1; io_write = 1'b1; io_out = 8'h3C;
    tick();
    io_read = 1'b0; io_write = 1'b0;
    $display("io_read+io_write 0x3C -> io_in=0x%02h tx_data=0x%02h", io_in, tx_data);
    checks++; if (io_in !== 8'h00) begin failures++; $display("FAIL cc_rx_gap got=%h exp=00", io_in); end
    checks++; if (tx_data !== 8'h3C) begin failures++; $display("FAIL cc_tx got=%h exp=3C", tx_data); end
    exp_st = (DEPTH == 1) ? 8'h02 : 8'h00;
    checks++; if (io_status !== exp_st) begin failures++; $display("FAIL cc_status got=%h exp=%h", io_status, exp_st); end
    tick();
    rx_valid = 1'b0;
    checks++; if (io_in !== 8'h42) begin failures++; $display("FAIL cc_rx_next got=%h exp=42", io_in); end
    io_read = 1'b1; tx_ready = 1'b1; tick(); io_read = 1'b0; tx_ready = 1'b0;
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL cc_end got=%h exp=04", io_status); end
  endtask

  task automatic test_reset_mid();
    do_write(8'h01);
    do_write(8'h02);
    rx_valid = 1'b1; rx_data = 8'h66; tick(); rx_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    $display("reset_n asserted mid-transfer");
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rm_tx got=%b/%h exp=0/00", tx_valid, tx_data); end
    checks++; if (rx_ready !== 1'b1 || io_in !== 8'h00) begin failures++; $display("FAIL rm_rx got=%b/%h exp=1/00", rx_ready, io_in); end
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL rm_status got=%h exp=04", io_status); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tx_ready = 1'b1;
    tick(); tick();
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rm_no_stale got=%b/%h exp=0/00", tx_valid, tx_data); end
    tx_ready = 1'b0;
  endtask

`ifndef NEANDER_IO_TXFIFO_EN
  task automatic test_single_reg();
    do_write(8'hE1);
    do_write(8'hE2);
    checks++; if (io_status !== 8'h0A) begin failures++; $display("FAIL sr_status got=%h exp=0A", io_status); end
    checks++; if (tx_data !== 8'hE1) begin failures++; $display("FAIL sr_head got=%h exp=E1", tx_data); end
    do_stat_read();
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    checks++; if (io_status !== 8'h04) begin failures++; $display("FAIL sr_end got=%h exp=04", io_status); end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_order();
    test_overflow();
    test_full_push_pop();
    test_rx();
    test_concurrent();
    test_reset_mid();
`ifndef NEANDER_IO_TXFIFO_EN
    test_single_reg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
